multi_button_conditioner: RTL and testbench

//  N-channel button front end: 2-FF sync, tick-sampled debounce, press/release

---
 rtl/btn_cond_pkg.sv | 7 +
 rtl/btn_channel.sv | 98 +++++++++
 rtl/multi_button_conditioner.sv | 53 +++++
 tb/tb_multi_button_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared types and constants for the multi-channel button conditioner
package btn_cond_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, HELD} hold_state_t;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: sync, tick-sampled debounce, edge pulses and long-press/repeat for one button
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int DB_SAMPLES   = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick,
  input  logic en,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);
  localparam int DW = $clog2(DB_SAMPLES + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = REPEAT_TICKS > 0 ? $clog2(REPEAT_TICKS + 1) : 1;
  logic [1:0] sync;
  logic [DW-1:0] db_cnt;
  logic stable, stable_d, differ, accept;
  hold_state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic long_n, rep_pulse_n;
  assign differ = sync[1] ^ stable;
  assign accept = differ && db_cnt == DW'(DB_SAMPLES - 1);
  assign level  = stable;
  // stable_d only advances while running so an edge seen during en=0 is reported on resume
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync          <= '0;
      db_cnt        <= '0;
      stable        <= 1'b0;
      stable_d      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (tick) begin
        db_cnt <= (!differ || accept) ? '0 : db_cnt + 1'b1;
        stable <= accept ? sync[1] : stable;
      end
      if (en) stable_d <= stable;
      press_pulse   <= en & stable & ~stable_d;
      release_pulse <= en & ~stable & stable_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      rep_cnt      <= rep_n;
      long_press   <= long_n;
      repeat_pulse <= rep_pulse_n;
    end
  end
  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    rep_n       = rep_cnt;
    long_n      = long_press;
    rep_pulse_n = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (stable) begin
          state_n = PRESS;
          hold_n  = '0;
        end
        PRESS: if (!stable) state_n = IDLE;
        else if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
          state_n     = HELD;
          long_n      = 1'b1;
          rep_pulse_n = 1'b1;
          rep_n       = '0;
        end else hold_n = hold_cnt + 1'b1;
        HELD: if (!stable) begin
          state_n = IDLE;
          long_n  = 1'b0;
        end else if (REPEAT_TICKS > 0 && rep_cnt == RW'(REPEAT_TICKS - 1)) begin
          rep_pulse_n = 1'b1;
          rep_n       = '0;
        end else rep_n = rep_cnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/multi_button_conditioner.sv
// multi_button_conditioner: shared debounce-tick prescaler driving N independent button channels
module multi_button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 500000,
  parameter int DB_SAMPLES   = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 25,
  parameter int EDGE_MODE    = 0
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] event_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_pressed
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre_cnt;
  logic tick;
  assign tick = en && pre_cnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk_in) begin
    if (rst) pre_cnt <= '0;
    else if (en) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DB_SAMPLES  (DB_SAMPLES),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk_in       (clk_in),
      .rst          (rst),
      .tick         (tick),
      .en           (en),
      .btn          (btn_in[i]),
      .level        (level_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
  assign event_pulse = EDGE_MODE == EDGE_FALL ? release_pulse :
                       EDGE_MODE == EDGE_BOTH ? press_pulse | release_pulse : press_pulse;
  assign any_pressed = |level_out;
endmodule

// File: tb/tb_multi_button_conditioner.sv
// tb_multi_button_conditioner: directed and random stimulus against a tick-counting reference model
module tb_multi_button_conditioner;
  localparam int NC = 4, TD = 4, DB = 3, HT = 5, RT = 2;
  logic clk_in = 1'b0, rst = 1'b1, en = 1'b0;
  logic [NC-1:0] btn_in = '0;
  logic [NC-1:0] level_out, press_pulse, release_pulse, long_press, repeat_pulse, ev0, ev1, ev2;
  logic any_pressed;
  logic [NC-1:0] l1, p1, r1, lp1, rp1, l2, p2, r2, lp2, rp2;
  logic a1, a2;
  int checks = 0, failures = 0;
  always #5 clk_in = ~clk_in;

  multi_button_conditioner #(.N_CH(NC), .TICK_DIV(TD), .DB_SAMPLES(DB), .HOLD_TICKS(HT),
    .REPEAT_TICKS(RT), .EDGE_MODE(0)) dut0 (.clk_in(clk_in), .rst(rst), .en(en), .btn_in(btn_in),
    .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_pulse(ev0), .long_press(long_press), .repeat_pulse(repeat_pulse), .any_pressed(any_pressed));
  multi_button_conditioner #(.N_CH(NC), .TICK_DIV(TD), .DB_SAMPLES(DB), .HOLD_TICKS(HT),
    .REPEAT_TICKS(RT), .EDGE_MODE(1)) dut1 (.clk_in(clk_in), .rst(rst), .en(en), .btn_in(btn_in),
    .level_out(l1), .press_pulse(p1), .release_pulse(r1), .event_pulse(ev1), .long_press(lp1),
    .repeat_pulse(rp1), .any_pressed(a1));
  multi_button_conditioner #(.N_CH(NC), .TICK_DIV(TD), .DB_SAMPLES(DB), .HOLD_TICKS(HT),
    .REPEAT_TICKS(RT), .EDGE_MODE(2)) dut2 (.clk_in(clk_in), .rst(rst), .en(en), .btn_in(btn_in),
    .level_out(l2), .press_pulse(p2), .release_pulse(r2), .event_pulse(ev2), .long_press(lp2),
    .repeat_pulse(rp2), .any_pressed(a2));

  // reference: enabled-cycle count gives tick phase, run = consecutive differing ticks,
  // held = consecutive ticks seen pressed; long press from HT+1, repeats every RT after
  int en_cyc = 0;
  int run[NC], held[NC];
  logic [NC-1:0] sq0 = '0, sq1 = '0, stab = '0, shown = '0;
  logic [NC-1:0] m_press = '0, m_rel = '0, m_long = '0, m_rep = '0;
  int pp[NC], rel[NC], rep_seen[NC], e0[NC], e1[NC], e2[NC];
  int any_seen = 0, pulse_seen = 0;
  logic saw_1001 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic tk, s, old;
    if (rst) begin
      en_cyc = 0; sq0 = '0; sq1 = '0; stab = '0; shown = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < NC; c++) begin run[c] = 0; held[c] = 0; end
    end else begin
      tk = en && (en_cyc % TD == TD - 1);
      if (en) en_cyc++;
      for (int c = 0; c < NC; c++) begin
        s = sq1[c];
        old = stab[c];
        if (tk) begin
          if (s != old) begin
            run[c]++;
            if (run[c] == DB) begin stab[c] = s; run[c] = 0; end
          end else run[c] = 0;
        end
        m_press[c] = en && old && !shown[c];
        m_rel[c] = en && !old && shown[c];
        if (en) shown[c] = old;
        m_rep[c] = 1'b0;
        if (tk) begin
          if (old) begin
            held[c]++;
            m_long[c] = held[c] > HT;
            m_rep[c] = held[c] > HT && (RT > 0 ? (held[c] - HT - 1) % RT == 0 : held[c] == HT + 1);
          end else begin
            held[c] = 0;
            m_long[c] = 1'b0;
          end
        end
      end
      sq1 = sq0;
      sq0 = btn_in;
    end
  endtask

  task automatic clr();
    for (int c = 0; c < NC; c++) begin pp[c] = 0; rel[c] = 0; rep_seen[c] = 0; e0[c] = 0; e1[c] = 0; e2[c] = 0; end
    any_seen = 0; pulse_seen = 0; saw_1001 = 1'b0;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      model_step();
      check("level", level_out, stab);
      check("press", press_pulse, m_press);
      check("release", release_pulse, m_rel);
      check("long", long_press, m_long);
      check("repeat", repeat_pulse, m_rep);
      check("any", any_pressed, |stab);
      check("event_rise", ev0, m_press);
      check("event_fall", ev1, m_rel);
      check("event_both", ev2, m_press | m_rel);
      for (int c = 0; c < NC; c++) begin
        pp[c] += int'(press_pulse[c]); rel[c] += int'(release_pulse[c]);
        rep_seen[c] += int'(repeat_pulse[c]);
        e0[c] += int'(ev0[c]); e1[c] += int'(ev1[c]); e2[c] += int'(ev2[c]);
      end
      any_seen += int'(any_pressed);
      if ((press_pulse | release_pulse | repeat_pulse | ev2) != '0) pulse_seen++;
      if (press_pulse == 4'b1001) saw_1001 = 1'b1;
    end
  endtask

  initial begin
    int k;
    logic found;
    rst = 1'b1; en = 1'b1;
    cyc(3);
    check("reset_level", level_out, 0);
    check("reset_long", long_press, 0);
    check("reset_pulses", press_pulse | release_pulse | repeat_pulse | ev2, 0);
    rst = 1'b0;
    cyc(8);
    clr(); btn_in[0] = 1'b1; cyc(80);
    check("clean_press_count", pp[0], 1);
    check("clean_level", level_out[0], 1);
    check("clean_long", long_press[0], 1);
    check("clean_repeat_range", rep_seen[0] >= 4 && rep_seen[0] <= 7, 1);
    clr(); btn_in[0] = 1'b0; cyc(24);
    check("clean_release_count", rel[0], 1);
    check("clean_long_cleared", long_press[0], 0);
    clr();
    for (int i = 0; i < 10; i++) begin btn_in[1] = ~btn_in[1]; cyc(4); end
    btn_in[1] = 1'b1; cyc(40);
    check("bounce_press_count", pp[1], 1);
    check("bounce_level", level_out[1], 1);
    btn_in[1] = 1'b0; cyc(24);
    clr(); btn_in[2] = 1'b1; cyc(8); btn_in[2] = 1'b0; cyc(24);
    check("glitch_any", any_seen, 0);
    check("glitch_pulses", pulse_seen, 0);
    clr(); btn_in = 4'b1001; cyc(56);
    check("simul_press", saw_1001, 1);
    check("simul_long", long_press, 4'b1001);
    clr(); en = 1'b0; cyc(50);
    check("en_off_pulses", pulse_seen, 0);
    check("en_off_long", long_press, 4'b1001);
    en = 1'b1; cyc(12);
    check("en_resume_repeat", rep_seen[0] > 0, 1);
    rst = 1'b1; cyc(1);
    check("rst_outputs", level_out | long_press | press_pulse | repeat_pulse | release_pulse, 0);
    check("rst_any", any_pressed, 0);
    rst = 1'b0; clr();
    k = 0; found = 1'b0;
    while (k < 40 && !found) begin cyc(1); k++; found = press_pulse[0]; end
    check("rst_repress_found", found, 1);
    check("rst_repress_latency", k, 13);
    btn_in = '0; cyc(24);
    check("edge_rise_count", e0[0], 1);
    check("edge_fall_count", e1[0], 1);
    check("edge_both_count", e2[0], 2);
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 2) != 0) btn_in = btn_in ^ 4'($urandom_range(0, 15));
      en = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 59) == 0;
      cyc($urandom_range(1, 60));
    end
    rst = 1'b0; en = 1'b1; cyc(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
